norm_shift_scheduler: RTL and testbench

- Shared mantissa normaliser for the sin/cos datapath, with two requesters: port 0 is the sin path, port 1 is the cos path.
- Round-robin arbitration between the two requesters.
- Locates the leading one of a 23-bit mantissa, left-shifts it so the leading one lands at bit 22, and decrements the exponent by the shift amount.
- Sequenced by a 4-state FSM so a single detector/shifter is time-shared; returns the result with a requester tag over ready/valid.

---
 rtl/norm_shift_scheduler_if.sv | 41 ++++
 rtl/norm_shift_scheduler.sv | 150 +++++++++++++++
 tb/tb_norm_shift_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/norm_shift_scheduler_if.sv
// Request/response bundle for the shared mantissa normaliser: two operand
// requesters (0 = sin, 1 = cos) and one tagged result channel.
interface norm_shift_scheduler_if #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
);
  logic              io_req0_valid;
  logic              io_req0_ready;
  logic [MANT_W-1:0] io_req0_mant;
  logic [EXP_W-1:0]  io_req0_exp;
  logic              io_req1_valid;
  logic              io_req1_ready;
  logic [MANT_W-1:0] io_req1_mant;
  logic [EXP_W-1:0]  io_req1_exp;
  logic              io_resp_valid;
  logic              io_resp_ready;
  logic              io_resp_id;
  logic [MANT_W-1:0] io_resp_mant;
  logic [EXP_W-1:0]  io_resp_exp;
  logic              io_resp_zero;
  logic              io_resp_uflow;
  logic              io_busy;

  modport slave (
    input  io_req0_valid, io_req0_mant, io_req0_exp,
    input  io_req1_valid, io_req1_mant, io_req1_exp,
    input  io_resp_ready,
    output io_req0_ready, io_req1_ready,
    output io_resp_valid, io_resp_id, io_resp_mant, io_resp_exp,
    output io_resp_zero, io_resp_uflow, io_busy
  );

  modport master (
    output io_req0_valid, io_req0_mant, io_req0_exp,
    output io_req1_valid, io_req1_mant, io_req1_exp,
    output io_resp_ready,
    input  io_req0_ready, io_req1_ready,
    input  io_resp_valid, io_resp_id, io_resp_mant, io_resp_exp,
    input  io_resp_zero, io_resp_uflow, io_busy
  );
endinterface

// File: rtl/norm_shift_scheduler.sv
// Time-shared leading-one normaliser with round-robin arbitration between the sin and cos paths.
// Optional macro NORM_UFLOW_EN: flush to zero with io_resp_uflow when the exponent would underflow.
module norm_shift_scheduler #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int POS_W  = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  norm_shift_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DETECT = 2'd1,
    S_SHIFT  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_ptr;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;

  logic [MANT_W-1:0] r_mant_p0;
  logic [EXP_W-1:0]  r_exp_p0;
  logic              r_id_p0;
  logic [POS_W-1:0]  r_pos_p1;
  logic              r_zero_p1;
  logic [MANT_W-1:0] r_mant_p2;
  logic [EXP_W-1:0]  r_exp_p2;
  logic              r_zero_p2;
  logic              r_uflow_p2;

  logic [POS_W-1:0]  w_pos;
  logic [POS_W-1:0]  w_shift;
  logic [MANT_W-1:0] w_mant_sh;
  logic [EXP_W-1:0]  w_exp_sub;
  logic              w_uflow;

  function automatic logic [POS_W-1:0] f_lead_one(input logic [MANT_W-1:0] m);
    logic [POS_W-1:0] pos;
    pos = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (m[i]) pos = POS_W'(i);
    end
    return pos;
  endfunction

  function automatic logic f_exp_uflow(input logic [EXP_W-1:0] e,
                                       input logic [POS_W-1:0] s);
    return (e < EXP_W'(s));
  endfunction

  // r_ptr holds the last granted requester; on a tie the other one wins.
  always_comb begin
    w_grant0 = bus.io_req0_valid && (!bus.io_req1_valid || r_ptr);
    w_grant1 = bus.io_req1_valid && (!bus.io_req0_valid || !r_ptr);
    w_accept = (r_state == S_IDLE) && (w_grant0 || w_grant1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DETECT;
      S_DETECT: w_next = S_SHIFT;
      S_SHIFT:  w_next = S_RESP;
      S_RESP:   if (bus.io_resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_accept) r_ptr <= w_grant1;
    end
  end

  assign w_pos     = f_lead_one(r_mant_p0);
  assign w_shift   = POS_W'(MANT_W - 1) - r_pos_p1;
  assign w_mant_sh = r_mant_p0 << w_shift;
  assign w_exp_sub = r_exp_p0 - EXP_W'(w_shift);

`ifdef NORM_UFLOW_EN
  assign w_uflow = f_exp_uflow(r_exp_p0, w_shift);
`else
  assign w_uflow = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mant_p0  <= '0;
      r_exp_p0   <= '0;
      r_id_p0    <= 1'b0;
      r_pos_p1   <= '0;
      r_zero_p1  <= 1'b0;
      r_mant_p2  <= '0;
      r_exp_p2   <= '0;
      r_zero_p2  <= 1'b0;
      r_uflow_p2 <= 1'b0;
    end else begin
      // p0: operand capture on the request handshake
      if (w_accept) begin
        r_mant_p0 <= w_grant1 ? bus.io_req1_mant : bus.io_req0_mant;
        r_exp_p0  <= w_grant1 ? bus.io_req1_exp  : bus.io_req0_exp;
        r_id_p0   <= w_grant1;
      end
      // p1: leading-one detect
      if (r_state == S_DETECT) begin
        r_pos_p1  <= w_pos;
        r_zero_p1 <= (r_mant_p0 == '0);
      end
      // p2: shift and exponent adjust; zero and underflow both flush the result
      if (r_state == S_SHIFT) begin
        if (r_zero_p1 || w_uflow) begin
          r_mant_p2  <= '0;
          r_exp_p2   <= '0;
          r_zero_p2  <= 1'b1;
          r_uflow_p2 <= !r_zero_p1;
        end else begin
          r_mant_p2  <= w_mant_sh;
          r_exp_p2   <= w_exp_sub;
          r_zero_p2  <= 1'b0;
          r_uflow_p2 <= 1'b0;
        end
      end
    end
  end

  assign bus.io_req0_ready = (r_state == S_IDLE) && w_grant0;
  assign bus.io_req1_ready = (r_state == S_IDLE) && w_grant1;
  assign bus.io_resp_valid = (r_state == S_RESP);
  assign bus.io_resp_id    = r_id_p0;
  assign bus.io_resp_mant  = r_mant_p2;
  assign bus.io_resp_exp   = r_exp_p2;
  assign bus.io_resp_zero  = r_zero_p2;
`ifdef NORM_UFLOW_EN
  assign bus.io_resp_uflow = r_uflow_p2;
`else
  assign bus.io_resp_uflow = 1'b0;
`endif
  assign bus.io_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_norm_shift_scheduler.sv
// Directed bench for norm_shift_scheduler: latency, normalisation, zero, arbitration,
// backpressure, underflow and mid-operation reset.
module tb_norm_shift_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  norm_shift_scheduler_if #(.MANT_W(23), .EXP_W(8)) bus ();

  norm_shift_scheduler #(.MANT_W(23), .EXP_W(8), .POS_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.io_req0_valid = 1'b0;
    bus.io_req0_mant  = '0;
    bus.io_req0_exp   = '0;
    bus.io_req1_valid = 1'b0;
    bus.io_req1_mant  = '0;
    bus.io_req1_exp   = '0;
    bus.io_resp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Issue one request on a single port, wait for the response (bounded) and complete the handshake.
  task automatic send_req(input bit port, input logic [22:0] m, input logic [7:0] e,
                          output int lat, output logic id, output logic [22:0] rm,
                          output logic [7:0] re, output logic rz, output logic ru);
    @(negedge clock);
    if (port) begin
      bus.io_req1_valid = 1'b1; bus.io_req1_mant = m; bus.io_req1_exp = e;
    end else begin
      bus.io_req0_valid = 1'b1; bus.io_req0_mant = m; bus.io_req0_exp = e;
    end
    @(posedge clock);
    #1;
    bus.io_req0_valid = 1'b0;
    bus.io_req1_valid = 1'b0;
    lat = 0;
    while (lat < 10 && !bus.io_resp_valid) begin
      @(negedge clock);
      lat++;
    end
    id = bus.io_resp_id; rm = bus.io_resp_mant; re = bus.io_resp_exp;
    rz = bus.io_resp_zero; ru = bus.io_resp_uflow;
    bus.io_resp_ready = 1'b1;
    @(posedge clock);
    #1 bus.io_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    pulse_reset();
    @(negedge clock);
    tests_run++;
    if ({bus.io_resp_valid, bus.io_busy, bus.io_req0_ready, bus.io_req1_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {bus.io_resp_valid, bus.io_busy, bus.io_req0_ready, bus.io_req1_ready});
    end
    tests_run++;
    if ({bus.io_resp_id, bus.io_resp_mant, bus.io_resp_exp, bus.io_resp_zero, bus.io_resp_uflow} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: mant=%h exp=%0d id=%b zero=%b uflow=%b required all 0",
               bus.io_resp_mant, bus.io_resp_exp, bus.io_resp_id, bus.io_resp_zero, bus.io_resp_uflow);
    end
  endtask

  task automatic test_single();
    int lat; logic id, rz, ru; logic [22:0] rm; logic [7:0] re;
    send_req(1'b0, 23'h000001, 8'd100, lat, id, rm, re, rz, ru);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++; $display("FAIL single_latency: got %0d required 3", lat);
    end
    tests_run++;
    if ({id, rm, re, rz, ru} !== {1'b0, 23'h400000, 8'd78, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_result: id=%b mant=%h exp=%0d zero=%b required id=0 mant=400000 exp=78 zero=0",
               id, rm, re, rz);
    end
    @(negedge clock);
    tests_run++;
    if ({bus.io_resp_valid, bus.io_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_release: valid/busy=%b required 00", {bus.io_resp_valid, bus.io_busy});
    end
  endtask

  task automatic test_passthrough();
    int lat; logic id, rz, ru; logic [22:0] rm; logic [7:0] re;
    send_req(1'b1, 23'h4ABCDE, 8'd5, lat, id, rm, re, rz, ru);
    tests_run++;
    if ({id, rm, re, rz} !== {1'b1, 23'h4ABCDE, 8'd5, 1'b0} || lat !== 3) begin
      tests_failed++;
      $display("FAIL passthrough: id=%b mant=%h exp=%0d zero=%b lat=%0d required 1 4abcde 5 0 3",
               id, rm, re, rz, lat);
    end
  endtask

  task automatic test_zero();
    int lat; logic id, rz, ru; logic [22:0] rm; logic [7:0] re;
    send_req(1'b0, 23'h000000, 8'd200, lat, id, rm, re, rz, ru);
    tests_run++;
    if ({id, rm, re, rz, ru} !== {1'b0, 23'h000000, 8'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL zero_operand: id=%b mant=%h exp=%0d zero=%b uflow=%b required 0 0 0 1 0",
               id, rm, re, rz, ru);
    end
  endtask

  task automatic test_contention();
    int g_cnt, r_cnt;
    int g_cyc[4];
    logic g_id[4];
    logic r_id[4];
    logic [22:0] r_mant[4];
    logic [7:0] r_exp[4];
    idle_inputs();
    pulse_reset();
    @(negedge clock);
    bus.io_req0_valid = 1'b1; bus.io_req0_mant = 23'h000001; bus.io_req0_exp = 8'd100;
    bus.io_req1_valid = 1'b1; bus.io_req1_mant = 23'h4ABCDE; bus.io_req1_exp = 8'd5;
    bus.io_resp_ready = 1'b1;
    g_cnt = 0; r_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.io_req0_ready && bus.io_req1_ready) begin
        tests_run++; tests_failed++;
        $display("FAIL dual_grant: both readies high at cycle %0d required one", c);
      end
      if ((bus.io_req0_ready || bus.io_req1_ready) && g_cnt < 4) begin
        g_id[g_cnt] = bus.io_req1_ready; g_cyc[g_cnt] = c; g_cnt++;
      end
      if (bus.io_resp_valid && r_cnt < 4) begin
        r_id[r_cnt] = bus.io_resp_id; r_mant[r_cnt] = bus.io_resp_mant;
        r_exp[r_cnt] = bus.io_resp_exp; r_cnt++;
      end
      @(negedge clock);
    end
    idle_inputs();
    tests_run++;
    if (g_cnt !== 4 || r_cnt !== 4) begin
      tests_failed++;
      $display("FAIL contention_count: grants=%0d resps=%0d required 4 4", g_cnt, r_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (g_id[i] !== i[0] || g_cyc[i] !== 4 * i) begin
          tests_failed++;
          $display("FAIL contention_grant%0d: id=%b cycle=%0d required id=%b cycle=%0d",
                   i, g_id[i], g_cyc[i], i[0], 4 * i);
        end
        tests_run++;
        if (r_id[i] !== i[0] || r_mant[i] !== (i[0] ? 23'h4ABCDE : 23'h400000) ||
            r_exp[i] !== (i[0] ? 8'd5 : 8'd78)) begin
          tests_failed++;
          $display("FAIL contention_resp%0d: id=%b mant=%h exp=%0d required id=%b",
                   i, r_id[i], r_mant[i], r_exp[i], i[0]);
        end
      end
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clock);
    bus.io_req1_valid = 1'b1; bus.io_req1_mant = 23'h0F0000; bus.io_req1_exp = 8'd50;
    @(posedge clock);
    #1 bus.io_req1_valid = 1'b0;
    lat = 0;
    while (lat < 10 && !bus.io_resp_valid) begin
      @(negedge clock);
      lat++;
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++; $display("FAIL bp_latency: got %0d required 3", lat);
    end
    bus.io_req0_valid = 1'b1;
    bus.io_req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++;
      if ({bus.io_resp_valid, bus.io_resp_id, bus.io_resp_mant, bus.io_resp_exp, bus.io_resp_zero,
           bus.io_req0_ready, bus.io_req1_ready, bus.io_busy} !==
          {1'b1, 1'b1, 23'h780000, 8'd47, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: valid=%b id=%b mant=%h exp=%0d rdy=%b%b busy=%b required 1 1 780000 47 00 1",
                 k, bus.io_resp_valid, bus.io_resp_id, bus.io_resp_mant, bus.io_resp_exp,
                 bus.io_req0_ready, bus.io_req1_ready, bus.io_busy);
      end
      @(negedge clock);
    end
    bus.io_req0_valid = 1'b0;
    bus.io_req1_valid = 1'b0;
    bus.io_resp_ready = 1'b1;
    @(posedge clock);
    #1 bus.io_resp_ready = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({bus.io_resp_valid, bus.io_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL bp_release: valid/busy=%b required 00", {bus.io_resp_valid, bus.io_busy});
    end
  endtask

  task automatic test_underflow();
    int lat; logic id, rz, ru; logic [22:0] rm; logic [7:0] re;
    send_req(1'b1, 23'h000100, 8'd10, lat, id, rm, re, rz, ru);
    tests_run++;
`ifdef NORM_UFLOW_EN
    if ({rm, re, rz, ru} !== {23'h000000, 8'd0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL underflow: mant=%h exp=%0d zero=%b uflow=%b required 0 0 1 1", rm, re, rz, ru);
    end
`else
    if ({rm, re, rz, ru} !== {23'h400000, 8'd252, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL underflow: mant=%h exp=%0d zero=%b uflow=%b required 400000 252 0 0", rm, re, rz, ru);
    end
`endif
    send_req(1'b0, 23'h000100, 8'd14, lat, id, rm, re, rz, ru);
    tests_run++;
    if ({rm, re, rz, ru} !== {23'h400000, 8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL exp_equal_shift: mant=%h exp=%0d zero=%b uflow=%b required 400000 0 0 0", rm, re, rz, ru);
    end
  endtask

  task automatic test_reset_in_shift();
    int seen;
    @(negedge clock);
    bus.io_req0_valid = 1'b1; bus.io_req0_mant = 23'h000010; bus.io_req0_exp = 8'd60;
    @(posedge clock);
    #1 bus.io_req0_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({bus.io_busy, bus.io_resp_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_shift_idle: busy/valid=%b required 00", {bus.io_busy, bus.io_resp_valid});
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (bus.io_resp_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++; $display("FAIL reset_shift_noresp: resp_valid seen %0d cycles required 0", seen);
    end
    bus.io_req0_valid = 1'b1;
    bus.io_req1_valid = 1'b1;
    #1;
    tests_run++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_shift_ptr: readies=%b required 10", {bus.io_req0_ready, bus.io_req1_ready});
    end
    idle_inputs();
    pulse_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_passthrough();
    test_zero();
    test_contention();
    test_backpressure();
    test_underflow();
    test_reset_in_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
